// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared register-writeback types: data/index widths and the {rd, data}
// entry that the ALU and load-unit stages also use.
package reg_writeback_ctrl_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of the result handshakes, the register-file write port and the
// pending-lookup signals. master = writeback controller, slave = its
// surroundings (ALU, load unit, register file, issue logic).
//
// Handshake: a result is transferred on a rising clk edge where both
// xx_valid and xx_ready are high. Ready is a function of the registered
// queue occupancy, flush and (for the ALU) ld_valid only; it never looks at
// alu_valid, so valid may safely depend on ready.
interface reg_writeback_ctrl_if
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int data_length = XLEN,
    parameter int addr_size   = REG_ADDR_W
);
    logic                   flush;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [addr_size-1:0]   alu_rd;
    logic [data_length-1:0] alu_data;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [addr_size-1:0]   ld_rd;
    logic [data_length-1:0] ld_data;
    logic                   reg_write;
    logic [addr_size-1:0]   write_reg;
    logic [data_length-1:0] write_data;
    logic [addr_size-1:0]   query_reg1;
    logic [addr_size-1:0]   query_reg2;
    logic                   pending1;
    logic                   pending2;

    modport master (
        input  flush, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               query_reg1, query_reg2,
        output alu_ready, ld_ready, reg_write, write_reg, write_data,
               pending1, pending2
    );

    modport slave (
        output flush, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               query_reg1, query_reg2,
        input  alu_ready, ld_ready, reg_write, write_reg, write_data,
               pending1, pending2
    );
endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// In-order circular writeback queue: two push ports (push0 lands first),
// one pop port, and per-entry rd match vectors for pending lookups.
// Caller guarantees pushes never exceed free space and pop only when count>0.
module wb_fifo
    import reg_writeback_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push0,
    input  wb_entry_t             push0_entry,
    input  logic                  push1,
    input  wb_entry_t             push1_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic [CW-1:0]         count,
    input  logic [REG_ADDR_W-1:0] query1,
    input  logic [REG_ADDR_W-1:0] query2,
    output logic [DEPTH-1:0]      hit1,
    output logic [DEPTH-1:0]      hit2
);
    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  tail_p1;

    assign tail_p1    = tail + PW'(1);
    assign head_entry = mem[head];

    // Storage write: push1 goes behind push0 when both arrive together.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push0) mem[tail] <= push0_entry;
            if (push1) mem[push0 ? tail_p1 : tail] <= push1_entry;
        end
    end

    // Pointers and occupancy; flush empties the queue synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push0) + PW'(push1);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PW-1:0] offset;
        logic          live;
        assign offset   = PW'(gi) - head;
        assign live     = CW'(offset) < count;
        assign hit1[gi] = live && (mem[gi].rd == query1);
        assign hit2[gi] = live && (mem[gi].rd == query2);
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write initiator: accepts load/ALU results, drops x0 writes,
// queues the rest in order and drains one per cycle onto the write port.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int data_length = XLEN,
    parameter int addr_size   = REG_ADDR_W,
    parameter int DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_writeback_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]          count;
    logic [CW-1:0]          free;
    logic                   ld_push;
    logic                   alu_push;
    logic                   pop;
    wb_entry_t              ld_entry;
    wb_entry_t              alu_entry;
    wb_entry_t              head_entry;
    logic [DEPTH-1:0]       hit1;
    logic [DEPTH-1:0]       hit2;
    logic                   reg_write_q;
    logic [addr_size-1:0]   write_reg_q;
    logic [data_length-1:0] write_data_q;

    // Space is judged on registered occupancy; a same-cycle pop is not credited.
    assign free          = CW'(DEPTH) - count;
    assign bus.ld_ready  = !bus.flush && (free >= CW'(1));
    assign bus.alu_ready = !bus.flush &&
                           ((free >= CW'(2)) || ((free >= CW'(1)) && !bus.ld_valid));

    // Writes to x0 finish the handshake but never occupy a slot.
    assign ld_push  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != '0);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign ld_entry  = '{rd: bus.ld_rd,  data: bus.ld_data};
    assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
    assign pop       = (count != '0) && !bus.flush;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (bus.flush),
        .push0       (ld_push),
        .push0_entry (ld_entry),
        .push1       (alu_push),
        .push1_entry (alu_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .count       (count),
        .query1      (bus.query_reg1),
        .query2      (bus.query_reg2),
        .hit1        (hit1),
        .hit2        (hit2)
    );

    // Register-file write port: one pulse per popped entry, index/data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (pop) begin
            reg_write_q  <= 1'b1;
            write_reg_q  <= head_entry.rd;
            write_data_q <= head_entry.data;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

    // A register is pending while queued or while its write is on the port.
    assign bus.pending1 = (bus.query_reg1 != '0) &&
                          ((|hit1) || (reg_write_q && (write_reg_q == bus.query_reg1)));
    assign bus.pending2 = (bus.query_reg2 != '0) &&
                          ((|hit2) || (reg_write_q && (write_reg_q == bus.query_reg2)));

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed vectors with literal expectations,
// plus a queue-level model compared against the DUT every negedge.
module tb_reg_writeback_ctrl;
    import reg_writeback_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = REG_ADDR_W + XLEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   dut_writes = 0;
    bit   cmp_en = 1'b0;

    // Model: entries held in the queue, plus the write-port register.
    logic [W-1:0]          exp_q[$];
    logic                  m_we = 1'b0;
    logic [REG_ADDR_W-1:0] m_wreg = '0;
    logic [XLEN-1:0]       m_wdata = '0;

    reg_writeback_ctrl_if #(.data_length(XLEN), .addr_size(REG_ADDR_W)) bus ();

    reg_writeback_ctrl #(.data_length(XLEN), .addr_size(REG_ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_pending(input logic [REG_ADDR_W-1:0] q);
        bit hit = (m_we && m_wreg == q);
        foreach (exp_q[i]) if (exp_q[i][W-1:XLEN] == q) hit = 1'b1;
        return (q != '0) && hit;
    endfunction

    // Model update at each edge, using pre-edge occupancy for the readies.
    always @(posedge clk or negedge rst_n) begin
        int free;
        bit ldr, alur;
        logic [W-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_we    <= 1'b0;
            m_wreg  <= '0;
            m_wdata <= '0;
        end else begin
            free = DEPTH - exp_q.size();
            ldr  = !bus.flush && free >= 1;
            alur = !bus.flush && (free >= 2 || (free >= 1 && !bus.ld_valid));
            if (bus.flush) begin
                exp_q.delete();
                m_we <= 1'b0;
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    m_we    <= 1'b1;
                    m_wreg  <= e[W-1:XLEN];
                    m_wdata <= e[XLEN-1:0];
                end else begin
                    m_we <= 1'b0;
                end
                if (bus.ld_valid && ldr && bus.ld_rd != '0) exp_q.push_back({bus.ld_rd, bus.ld_data});
                if (bus.alu_valid && alur && bus.alu_rd != '0) exp_q.push_back({bus.alu_rd, bus.alu_data});
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int free;
        if (cmp_en) begin
            free = DEPTH - exp_q.size();
            check("ld_ready", 64'(bus.ld_ready), 64'(!bus.flush && free >= 1));
            check("alu_ready", 64'(bus.alu_ready),
                  64'(!bus.flush && (free >= 2 || (free >= 1 && !bus.ld_valid))));
            check("reg_write", 64'(bus.reg_write), 64'(m_we));
            check("write_reg", 64'(bus.write_reg), 64'(m_wreg));
            check("write_data", bus.write_data, m_wdata);
            check("pending1", 64'(bus.pending1), 64'(model_pending(bus.query_reg1)));
            check("pending2", 64'(bus.pending2), 64'(model_pending(bus.query_reg2)));
            if (bus.reg_write) dut_writes++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic v, input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    task automatic set_alu(input logic v, input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    initial begin
        int base;
        int ls, as_, guard;
        bit la, aa, saw_block;

        bus.flush = 1'b0;
        set_ld(1'b0, '0, '0);
        set_alu(1'b0, '0, '0);
        bus.query_reg1 = '0;
        bus.query_reg2 = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_reg_write", 64'(bus.reg_write), 64'd0);
        check("rst_write_reg", 64'(bus.write_reg), 64'd0);
        check("rst_write_data", bus.write_data, 64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("rst_pending1", 64'(bus.pending1), 64'd0);
        cmp_en = 1'b1;

        // Single ALU write {1, 22}
        cyc();
        bus.query_reg1 = 5'd1;
        set_alu(1'b1, 5'd1, 64'd22);
        #1 check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        cyc();
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        check("t1_e0_reg_write", 64'(bus.reg_write), 64'd0);
        check("t1_e0_pending1", 64'(bus.pending1), 64'd1);
        cyc();
        @(negedge clk);
        check("t1_e1_reg_write", 64'(bus.reg_write), 64'd1);
        check("t1_e1_write_reg", 64'(bus.write_reg), 64'd1);
        check("t1_e1_write_data", bus.write_data, 64'd22);
        check("t1_e1_pending1", 64'(bus.pending1), 64'd1);
        cyc();
        @(negedge clk);
        check("t1_e2_reg_write", 64'(bus.reg_write), 64'd0);
        check("t1_e2_pending1", 64'(bus.pending1), 64'd0);

        // Same-cycle load {10, 6} and ALU {11, F}
        cyc();
        bus.query_reg1 = 5'd10;
        bus.query_reg2 = 5'd11;
        set_ld(1'b1, 5'd10, 64'h6);
        set_alu(1'b1, 5'd11, 64'hF);
        #1;
        check("t2_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("t2_alu_ready", 64'(bus.alu_ready), 64'd1);
        cyc();
        set_ld(1'b0, '0, '0);
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        check("t2_q_pending1", 64'(bus.pending1), 64'd1);
        check("t2_q_pending2", 64'(bus.pending2), 64'd1);
        cyc();
        @(negedge clk);
        check("t2_w0_reg_write", 64'(bus.reg_write), 64'd1);
        check("t2_w0_write_reg", 64'(bus.write_reg), 64'd10);
        check("t2_w0_write_data", bus.write_data, 64'h6);
        cyc();
        @(negedge clk);
        check("t2_w1_reg_write", 64'(bus.reg_write), 64'd1);
        check("t2_w1_write_reg", 64'(bus.write_reg), 64'd11);
        check("t2_w1_write_data", bus.write_data, 64'hF);
        check("t2_w1_pending1", 64'(bus.pending1), 64'd0);
        check("t2_w1_pending2", 64'(bus.pending2), 64'd1);
        cyc();
        @(negedge clk);
        check("t2_idle_reg_write", 64'(bus.reg_write), 64'd0);

        // Continuous traffic: 10 loads + 10 ALU results
        cyc();
        base = dut_writes;
        ls = 0;
        as_ = 0;
        guard = 0;
        saw_block = 1'b0;
        bus.query_reg1 = 5'd3;
        bus.query_reg2 = 5'd18;
        while ((ls < 10 || as_ < 10) && guard < 100) begin
            set_ld(ls < 10, 5'(1 + ls), 64'(64'h100 + ls));
            set_alu(as_ < 10, 5'(16 + as_), 64'(64'h200 + as_));
            #1;
            la = bus.ld_valid && bus.ld_ready;
            aa = bus.alu_valid && bus.alu_ready;
            if (bus.ld_valid && bus.ld_ready && bus.alu_valid && !bus.alu_ready) saw_block = 1'b1;
            cyc();
            if (la) ls++;
            if (aa) as_++;
            guard++;
        end
        check("t3_all_accepted", 64'(ls + as_), 64'd20);
        set_ld(1'b0, '0, '0);
        set_alu(1'b0, '0, '0);
        repeat (8) cyc();
        check("t3_write_count", 64'(dut_writes - base), 64'd20);
        check("t3_alu_blocked_seen", 64'(saw_block), 64'd1);

        // ALU write to x0 is dropped
        bus.query_reg1 = '0;
        bus.query_reg2 = '0;
        base = dut_writes;
        set_alu(1'b1, 5'd0, 64'h55);
        #1 check("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
        cyc();
        set_alu(1'b0, '0, '0);
        repeat (3) begin
            @(negedge clk);
            check("t4_reg_write", 64'(bus.reg_write), 64'd0);
            check("t4_pending1", 64'(bus.pending1), 64'd0);
            cyc();
        end
        check("t4_write_count", 64'(dut_writes - base), 64'd0);

        // Flush with three entries queued
        set_ld(1'b1, 5'd3, 64'h33);
        set_alu(1'b1, 5'd4, 64'h44);
        cyc();
        set_ld(1'b1, 5'd5, 64'h55);
        set_alu(1'b1, 5'd6, 64'h66);
        #1;
        check("t5_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("t5_alu_ready", 64'(bus.alu_ready), 64'd1);
        cyc();
        bus.query_reg1 = 5'd5;
        bus.query_reg2 = 5'd6;
        bus.flush = 1'b1;
        #1;
        check("t5_flush_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("t5_flush_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("t5_pre_pending1", 64'(bus.pending1), 64'd1);
        cyc();
        bus.flush = 1'b0;
        set_ld(1'b0, '0, '0);
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        check("t5_post_reg_write", 64'(bus.reg_write), 64'd0);
        check("t5_post_pending1", 64'(bus.pending1), 64'd0);
        check("t5_post_pending2", 64'(bus.pending2), 64'd0);
        cyc();
        @(negedge clk);
        check("t5_empty_reg_write", 64'(bus.reg_write), 64'd0);

        // Asynchronous reset while a write is on the port
        cyc();
        bus.query_reg1 = 5'd8;
        set_ld(1'b1, 5'd7, 64'h77);
        set_alu(1'b1, 5'd8, 64'h88);
        cyc();
        set_ld(1'b0, '0, '0);
        set_alu(1'b0, '0, '0);
        cyc();
        check("t6_pre_reg_write", 64'(bus.reg_write), 64'd1);
        check("t6_pre_write_reg", 64'(bus.write_reg), 64'd7);
        rst_n = 1'b0;
        #1;
        check("t6_async_reg_write", 64'(bus.reg_write), 64'd0);
        check("t6_async_pending1", 64'(bus.pending1), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        check("t6_after_reg_write", 64'(bus.reg_write), 64'd0);
        check("t6_after_write_reg", 64'(bus.write_reg), 64'd0);
        check("t6_after_pending1", 64'(bus.pending1), 64'd0);
        cyc();
        cyc();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
